detect_faces_mac_pipe: RTL and testbench
========================================

DETECT_FACES_MAC_PIPE -- requirements
Module: detect_faces_mac_pipe

Interface
REQ-001 The block SHALL have parameter DIN0_WIDTH, default 16, width of operand din0.
REQ-002 The block SHALL have parameter DIN1_WIDTH, default 8, width of operand din1.
REQ-003 The block SHALL have parameter DOUT_WIDTH, default 32, result/accumulator width; legal only if DOUT_WIDTH >= DIN0_WIDTH + DIN1_WIDTH + 1.
REQ-004 The block SHALL have parameter NUM_STAGE, default 3, pipeline depth; legal range 1..4.
REQ-005 The block SHALL have parameter DIN0_SIGNED, default 0; 0 = din0 unsigned, 1 = two's complement.
REQ-006 The block SHALL have parameter DIN1_SIGNED, default 1; same encoding for din1.
REQ-007 The block SHALL have port ap_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-008 The block SHALL have port ap_rst_n, input, 1, reset; asynchronous and active-low.
REQ-009 The block SHALL have port in_valid, input, 1, input sample present.
REQ-010 The block SHALL have port in_ready, output, 1, block accepts a sample this cycle.
REQ-011 The block SHALL have port din0, input, DIN0_WIDTH, operand 0.
REQ-012 The block SHALL have port din1, input, DIN1_WIDTH, operand 1.
REQ-013 The block SHALL have port acc_en, input, 1, sideband travelling with the sample; 1 = add the product to the accumulator.
REQ-014 The block SHALL have port acc_clr, input, 1, sideband travelling with the sample; 1 = zero the accumulator before this sample.
REQ-015 The block SHALL have port out_valid, output, 1, dout holds a result.
REQ-016 The block SHALL have port out_ready, input, 1, consumer takes the result.
REQ-017 The block SHALL have port dout, output, DOUT_WIDTH, signed result.
REQ-018 The block SHALL have port ovf, output, 1, per-result flag: the result was saturated.

Function
REQ-019 Each operand SHALL be extended by one bit: sign bit if signed, zero if unsigned; product = signed multiply of both extended operands, sign-extended to DOUT_WIDTH.
REQ-020 A sample SHALL be accepted on any cycle with in_valid=1 and in_ready=1.
REQ-021 The pipeline SHALL hold NUM_STAGE register stages, each carrying a valid bit, partial data, acc_en and acc_clr.
REQ-022 in_ready SHALL equal NOT(out_valid AND NOT out_ready); all stages advance together when in_ready=1 and hold their contents when in_ready=0.
REQ-023 With no stall, a sample accepted at edge t SHALL be presented with out_valid=1 after edge t+NUM_STAGE-1, i.e. latency of NUM_STAGE cycles.
REQ-024 Bubbles (in_valid=0 during an advance) SHALL propagate as invalid stages; out_valid SHALL be the valid bit of the final stage.
REQ-025 The accumulator register acc (DOUT_WIDTH, signed) SHALL update only when a valid sample enters the final stage.
REQ-026 Base value SHALL be 0 if acc_clr=1, else acc.
REQ-027 If acc_en=1: result = sat(base + product), and acc <= result.
REQ-028 If acc_en=0: result = product; acc <= 0 if acc_clr=1, else acc is unchanged.
REQ-029 sat SHALL clamp to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1], using a DOUT_WIDTH+1-bit intermediate sum.
REQ-030 ovf SHALL be 1 exactly when clamping occurred; it is registered together with dout.
REQ-031 dout and ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-032 Invalid samples SHALL never modify acc.

Reset
REQ-033 While ap_rst_n=0: all stage valid bits, out_valid, dout, ovf and acc SHALL be 0, and in_ready SHALL be 1.
REQ-034 Assertion of ap_rst_n SHALL take effect immediately, without waiting for a clock edge; in-flight samples are discarded.
REQ-035 Deassertion of ap_rst_n SHALL be synchronised internally; the first sample may be accepted on the second rising edge after deassertion.

Verification
REQ-036 Defaults, din0=65535, din1=0x80 (-128), acc_en=0 -> after 3 cycles dout=-8388480, ovf=0.
REQ-037 acc_clr=1,acc_en=1 on sample (100,3), then acc_en=1 on samples (200,-2) and (1,1) -> dout sequence 300, -100, -99.
REQ-038 out_ready=0 held for 5 cycles while 4 samples are streamed -> in_ready drops; no loss or duplication; original order and values resume after out_ready=1.
REQ-039 acc preloaded near 2^31-1 by repeated 65535*127 accumulation -> dout=2147483647 with ovf=1; the next acc_clr sample restarts from 0.
REQ-040 ap_rst_n pulsed low mid-stream with 2 samples in flight -> out_valid=0 and acc=0 immediately; no stale result after reset is released.
REQ-041 NUM_STAGE=1 and DIN0_SIGNED=1: din0=-1, din1=-1 -> dout=1 one cycle after acceptance; back-to-back throughput of 1 sample per cycle.

Source files
------------

// File: rtl/detect_faces_mac_pipe.sv
// Pipelined multiply-accumulate with saturating accumulator and
// valid/ready flow control; all stages stall together on backpressure.
module detect_faces_mac_pipe #(
   parameter int DIN0_WIDTH  = 16,
   parameter int DIN1_WIDTH  = 8,
   parameter int DOUT_WIDTH  = 32,
   parameter int NUM_STAGE   = 3,
   parameter int DIN0_SIGNED = 0,
   parameter int DIN1_SIGNED = 1
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIN0_WIDTH-1:0] din0,
   input  logic [DIN1_WIDTH-1:0] din1,
   input  logic                  acc_en,
   input  logic                  acc_clr,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DOUT_WIDTH-1:0] dout,
   output logic                  ovf
);

   localparam int N  = NUM_STAGE;
   localparam int DW = DOUT_WIDTH;

   logic                 arm;
   logic                 fv, fen, fclr;
   logic signed [DW-1:0] fp;
   logic signed [DW-1:0] acc;
   logic signed [DW-1:0] a_x, b_x, prod, base, res;
   logic signed [DW:0]   sum;
   logic                 clip;

   assign in_ready = ~(out_valid & ~out_ready);

   // Deassertion is registered once so acceptance starts on the second edge
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) arm <= 1'b0;
      else           arm <= 1'b1;
   end

   always_comb begin
      a_x = {{(DW-DIN0_WIDTH){(DIN0_SIGNED != 0) & din0[DIN0_WIDTH-1]}}, din0};
      b_x = {{(DW-DIN1_WIDTH){(DIN1_SIGNED != 0) & din1[DIN1_WIDTH-1]}}, din1};
      prod = a_x * b_x;
   end

   generate
      if (N == 1) begin : g_direct
         assign fv   = in_valid & arm;
         assign fen  = acc_en;
         assign fclr = acc_clr;
         assign fp   = prod;
      end else begin : g_stages
         logic [N-2:0]         v, en, clr;
         logic signed [DW-1:0] p [N-1];

         always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
               v   <= '0;
               en  <= '0;
               clr <= '0;
               for (int i = 0; i < N-1; i++) p[i] <= '0;
            end else if (in_ready) begin
               v[0]   <= in_valid & arm;
               en[0]  <= acc_en;
               clr[0] <= acc_clr;
               p[0]   <= prod;
               for (int i = 1; i < N-1; i++) begin
                  v[i]   <= v[i-1];
                  en[i]  <= en[i-1];
                  clr[i] <= clr[i-1];
                  p[i]   <= p[i-1];
               end
            end
         end

         assign fv   = v[N-2];
         assign fen  = en[N-2];
         assign fclr = clr[N-2];
         assign fp   = p[N-2];
      end
   endgenerate

   // One extra sum bit exposes overflow in either direction
   always_comb begin
      base = fclr ? '0 : acc;
      sum  = {base[DW-1], base} + {fp[DW-1], fp};
      clip = 1'b0;
      res  = fp;
      if (fen) begin
         res = sum[DW-1:0];
         if (sum[DW] != sum[DW-1]) begin
            clip = 1'b1;
            res  = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
         end
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         out_valid <= 1'b0;
         dout      <= '0;
         ovf       <= 1'b0;
         acc       <= '0;
      end else if (in_ready) begin
         out_valid <= fv;
         if (fv) begin
            dout <= res;
            ovf  <= clip;
            if (fen)       acc <= res;
            else if (fclr) acc <= '0;
         end
      end
   end

endmodule

// File: tb/tb_detect_faces_mac_pipe.sv
// Randomised and directed bench for detect_faces_mac_pipe with an
// arithmetic reference model and an in-order result scoreboard.
`timescale 1ns/1ps
module tb_detect_faces_mac_pipe;

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid, in_ready, acc_en, acc_clr;
   logic        out_valid, out_ready, ovf;
   logic [15:0] din0;
   logic [7:0]  din1;
   logic [31:0] dout;

   logic        v1, r1, ov1, f1, zero1;
   logic [15:0] a1;
   logic [7:0]  b1;
   logic [31:0] d1;

   always #5 clk = ~clk;

   detect_faces_mac_pipe u0 (
      .ap_clk(clk), .ap_rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .din0(din0), .din1(din1),
      .acc_en(acc_en), .acc_clr(acc_clr),
      .out_valid(out_valid), .out_ready(out_ready),
      .dout(dout), .ovf(ovf)
   );

   detect_faces_mac_pipe #(.NUM_STAGE(1), .DIN0_SIGNED(1)) u1 (
      .ap_clk(clk), .ap_rst_n(rst_n),
      .in_valid(v1), .in_ready(r1),
      .din0(a1), .din1(b1),
      .acc_en(zero1), .acc_clr(zero1),
      .out_valid(ov1), .out_ready(1'b1),
      .dout(d1), .ovf(f1)
   );

   typedef struct {
      longint d;
      bit     o;
   } res_t;

   res_t        exp_q[$];
   logic [31:0] got_q[$];
   logic        gov_q[$];
   longint      macc = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   int          ir_low = 0;

   function automatic void check(string name, longint act, longint req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endfunction

   function automatic void model_accept(logic [15:0] a, logic [7:0] b,
                                        logic en, logic clr);
      longint p, s, r;
      bit     o;
      p = longint'(a) * longint'($signed(b));
      s = (clr ? 0 : macc) + p;
      o = 1'b0;
      r = p;
      if (en) begin
         r = s;
         if (s > SMAX) begin r = SMAX; o = 1'b1; end
         if (s < SMIN) begin r = SMIN; o = 1'b1; end
         macc = r;
      end else if (clr) begin
         macc = 0;
      end
      exp_q.push_back('{r, o});
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         check("in_ready", in_ready, !(out_valid && !out_ready));
         if (!in_ready) ir_low++;
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", 1, 0);
            end else begin
               check("dout", longint'($signed(dout)), exp_q[0].d);
               check("ovf", ovf, exp_q[0].o);
               if (out_ready) begin
                  got_q.push_back(dout);
                  gov_q.push_back(ovf);
                  void'(exp_q.pop_front());
               end
            end
         end
         if (in_valid && in_ready) model_accept(din0, din1, acc_en, acc_clr);
      end
   end

   task automatic send(logic [15:0] a, logic [7:0] b, logic en, logic clr);
      in_valid = 1'b1;
      din0 = a;
      din1 = b;
      acc_en = en;
      acc_clr = clr;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1 in_valid = 1'b0;
            return;
         end
      end
      check("send_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int k = 0; k < 200; k++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
      end
      check("drain_left", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   function automatic longint got(int back);
      return longint'($signed(got_q[got_q.size() - back]));
   endfunction

   initial begin
      #1000000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1);
   end

   initial begin
      int g0, i0;
      longint e1 [3];
      in_valid = 0; acc_en = 0; acc_clr = 0; din0 = 0; din1 = 0;
      out_ready = 1; v1 = 0; a1 = 0; b1 = 0; zero1 = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_dout", dout, 0);
      check("rst_ovf", ovf, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_u1_valid", ov1, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // unsigned 65535 times signed -128, latency 3
      send(16'hFFFF, 8'h80, 0, 0);
      check("lat_edge1", out_valid, 0);
      @(posedge clk);
      #1 check("lat_edge2", out_valid, 0);
      @(posedge clk);
      #1 check("lat_edge3", out_valid, 1);
      check("mul_dout", longint'($signed(dout)), -8388480);
      check("mul_ovf", ovf, 0);
      drain();

      send(16'd100, 8'd3, 1, 1);
      send(16'd200, 8'hFE, 1, 0);
      send(16'd1, 8'd1, 1, 0);
      drain();
      check("acc_seq0", got(3), 300);
      check("acc_seq1", got(2), -100);
      check("acc_seq2", got(1), -99);

      g0 = got_q.size();
      i0 = ir_low;
      out_ready = 1'b0;
      fork
         begin
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
         end
         begin
            send(16'd3, 8'd4, 0, 0);
            send(16'd5, 8'd6, 0, 0);
            send(16'd7, 8'd8, 0, 0);
            send(16'd9, 8'd10, 0, 0);
         end
      join
      drain();
      check("stall_ready_drop", ir_low > i0, 1);
      check("stall_count", got_q.size() - g0, 4);
      check("stall_o0", got(4), 12);
      check("stall_o1", got(3), 30);
      check("stall_o2", got(2), 56);
      check("stall_o3", got(1), 90);

      send(16'hFFFF, 8'd127, 1, 1);
      for (int k = 0; k < 258; k++) send(16'hFFFF, 8'd127, 1, 0);
      drain();
      check("sat_prev", got(2), 2147319810);
      check("sat_prev_ovf", gov_q[gov_q.size()-2], 0);
      check("sat_dout", got(1), 2147483647);
      check("sat_ovf", gov_q[gov_q.size()-1], 1);
      send(16'd2, 8'd3, 1, 1);
      drain();
      check("sat_restart", got(1), 6);
      check("sat_restart_ovf", gov_q[gov_q.size()-1], 0);

      send(16'd10, 8'd10, 1, 0);
      send(16'd11, 8'd11, 1, 0);
      send(16'd12, 8'd12, 1, 0);
      check("pre_rst_valid", out_valid, 1);
      #1 rst_n = 1'b0;
      exp_q.delete();
      macc = 0;
      #1;
      check("async_valid", out_valid, 0);
      check("async_dout", dout, 0);
      check("async_in_ready", in_ready, 1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1 check("post_rst_idle", out_valid, 0);
      send(16'd5, 8'd5, 1, 0);
      drain();
      check("post_rst_acc", got(1), 25);

      for (int k = 0; k < 400; k++) begin
         out_ready = ($urandom_range(3) != 0);
         in_valid  = ($urandom_range(2) != 0);
         din0      = 16'($urandom);
         din1      = 8'($urandom);
         acc_en    = ($urandom_range(3) != 0);
         acc_clr   = ($urandom_range(7) == 0);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      drain();

      e1 = '{1, 6, -20};
      v1 = 1'b1; a1 = 16'hFFFF; b1 = 8'hFF;
      for (int k = 0; k < 3; k++) begin
         check("u1_ready", r1, 1);
         @(posedge clk);
         #1;
         if (k == 0) begin a1 = 16'd2; b1 = 8'd3; end
         else if (k == 1) begin a1 = 16'hFFFC; b1 = 8'd5; end
         else v1 = 1'b0;
         @(negedge clk);
         check("u1_valid", ov1, 1);
         check("u1_dout", longint'($signed(d1)), e1[k]);
         check("u1_ovf", f1, 0);
      end
      @(posedge clk);
      #1 check("u1_idle", ov1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
